oam_dma: RTL and testbench



---
 rtl/nes_bus_pkg.sv | 18 +
 rtl/cpu_tick.sv | 22 ++
 rtl/oam_dma.sv | 128 ++++++++++++
 tb/tb_oam_dma.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_bus_pkg.sv
// Shared host-bus constants and the sprite DMA state type.
package nes_bus_pkg;

  // Host address that starts a sprite DMA transfer.
  localparam logic [15:0] TRIG_ADDR = 16'h4014;
  // PPU OAMDATA register, the destination of every DMA write.
  localparam logic [15:0] OAM_ADDR  = 16'h2004;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    DUMMY,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

endpackage

// File: rtl/cpu_tick.sv
// CPU cycle boundary detector: one-clock strobe on a falling edge of phi2.
module cpu_tick (
  input  logic I_clock,
  input  logic I_reset,
  input  logic I_phy2,
  output logic O_tick
);

  logic r_phy2;

  // Remember last clock's phi2 so its falling edge can be spotted.
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      r_phy2 <= 1'b0;
    end else begin
      r_phy2 <= I_phy2;
    end
  end

  assign O_tick = r_phy2 & ~I_phy2;

endmodule

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to the trigger address copies one page into OAM,
// halting the core and taking over the host bus for the duration.
module oam_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] P_trig_addr = TRIG_ADDR,
  parameter logic [15:0] P_oam_addr  = OAM_ADDR,
  parameter int unsigned P_count     = 256
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_phy2,
  input  logic [15:0] I_host_addr,
  input  logic        I_host_rdwr,
  input  logic [7:0]  I_host_data,
  input  logic [7:0]  I_rd_data,
  output logic        O_ready,
  output logic        O_bus_own,
  output logic [15:0] O_addr,
  output logic        O_rdwr,
  output logic [7:0]  O_wr_data,
  output logic        O_busy
);

  localparam logic [7:0] LAST_IDX = 8'(P_count - 1);

  logic       w_tick;
  dma_state_t r_state;
  dma_state_t w_state;
  logic [7:0] r_page;
  logic [7:0] r_index;
  logic [7:0] r_wr_data;
  // 0 = get cycle, 1 = put cycle; runs freely so DMA can align to it.
  logic       r_parity;
  logic       w_trigger;

  cpu_tick u_cpu_tick (
    .I_clock (I_clock),
    .I_reset (I_reset),
    .I_phy2  (I_phy2),
    .O_tick  (w_tick)
  );

  assign w_trigger = (I_host_addr == P_trig_addr) && !I_host_rdwr;

  // Next-state decode; only CPU cycle boundaries move the FSM.
  always_comb begin
    w_state = r_state;
    if (w_tick) begin
      unique case (r_state)
        IDLE:    if (w_trigger) w_state = HALT;
        // The 6502 only honours RDY on reads, so wait for one.
        HALT:    if (I_host_rdwr) w_state = DUMMY;
        // Parity is about to toggle: 1 now means the next cycle is a get.
        DUMMY:   w_state = r_parity ? READ : ALIGN;
        ALIGN:   w_state = READ;
        READ:    w_state = WRITE;
        WRITE:   w_state = (r_index == LAST_IDX) ? IDLE : READ;
        default: w_state = IDLE;
      endcase
    end
  end

  // State, parity, page, index and data registers.
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      r_state   <= IDLE;
      r_parity  <= 1'b0;
      r_page    <= 8'h00;
      r_index   <= 8'h00;
      r_wr_data <= 8'h00;
    end else begin
      r_state <= w_state;
      if (w_tick) begin
        r_parity <= ~r_parity;
        if (r_state == IDLE && w_trigger) begin
          r_page <= I_host_data;
        end
        if (r_state == READ) begin
          r_wr_data <= I_rd_data;
        end
        if (r_state == WRITE) begin
          r_index <= (r_index == LAST_IDX) ? 8'h00 : r_index + 8'h01;
        end
      end
    end
  end

  // Bus drive and handshake outputs follow directly from the state.
  always_comb begin
    O_ready   = 1'b0;
    O_bus_own = 1'b1;
    O_addr    = P_oam_addr;
    O_rdwr    = 1'b1;
    O_busy    = 1'b1;
    unique case (r_state)
      IDLE: begin
        O_ready   = 1'b1;
        O_bus_own = 1'b0;
        O_addr    = 16'h0000;
        O_busy    = 1'b0;
      end
      HALT: begin
        O_bus_own = 1'b0;
        O_addr    = 16'h0000;
      end
      DUMMY, ALIGN: begin
        O_addr = P_oam_addr;
      end
      READ: begin
        O_addr = {r_page, r_index};
      end
      WRITE: begin
        O_addr = P_oam_addr;
        O_rdwr = 1'b0;
      end
      default: begin
        O_ready   = 1'b1;
        O_bus_own = 1'b0;
        O_addr    = 16'h0000;
        O_busy    = 1'b0;
      end
    endcase
  end

  assign O_wr_data = r_wr_data;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: the bench plays the 6502 one CPU cycle at
// a time, owns a flat 64 KiB memory, and predicts each transfer from the
// page contents and the tick-parity rule.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        phy2;
  logic [15:0] haddr;
  logic        hrdwr;
  logic [7:0]  hdata;
  logic [7:0]  rd_data;
  logic        ready;
  logic        own;
  logic [15:0] addr;
  logic        rdwr;
  logic [7:0]  wr_data;
  logic        busy;
  logic [15:0] bus_addr;

  logic [7:0] mem [0:65535];

  always #5 clk = ~clk;

  assign bus_addr = own ? addr : haddr;
  assign rd_data  = mem[bus_addr];

  oam_dma dut (
    .I_clock     (clk),
    .I_reset     (rst),
    .I_phy2      (phy2),
    .I_host_addr (haddr),
    .I_host_rdwr (hrdwr),
    .I_host_data (hdata),
    .I_rd_data   (rd_data),
    .O_ready     (ready),
    .O_bus_own   (own),
    .O_addr      (addr),
    .O_rdwr      (rdwr),
    .O_wr_data   (wr_data),
    .O_busy      (busy)
  );

  int checks = 0;
  int errors = 0;
  int tick_cnt;
  int own_cnt, ready_low, halt_cnt, own_write;
  logic [15:0] rd_q [$];
  logic [7:0]  oam_q [$];
  logic        s_ready, s_own, s_busy;
  logic [15:0] s_addr;

  typedef struct {
    logic [7:0] page;
    int         nw;
    int         pad;
    int         exp_halt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One CPU cycle: phi2 high one clock, low one clock; the tick is the
  // rising clock edge after phi2 drops. Outputs are sampled just before it.
  task automatic cpu_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d,
                           input logic rst_at_tick = 1'b0);
    @(negedge clk);
    haddr = a;
    hrdwr = rw;
    hdata = d;
    phy2  = 1'b1;
    @(negedge clk);
    phy2 = 1'b0;
    #1;
    s_ready = ready;
    s_own   = own;
    s_busy  = busy;
    s_addr  = addr;
    if (!ready) ready_low++;
    if (own) own_cnt++;
    if (!ready && !own) halt_cnt++;
    if (own) begin
      if (!rw) own_write++;
      if (rdwr) begin
        if (addr != 16'h2004) rd_q.push_back(addr);
      end else if (addr == 16'h2004) begin
        oam_q.push_back(wr_data);
      end
    end else if (!rw) begin
      mem[a] = d;
    end
    if (rst_at_tick) begin
      rst      = 1'b1;
      tick_cnt = 0;
    end else begin
      tick_cnt++;
    end
  endtask

  task automatic clear_counters();
    own_cnt   = 0;
    ready_low = 0;
    halt_cnt  = 0;
    own_write = 0;
    rd_q.delete();
    oam_q.delete();
  endtask

  // Full transfer with nw core writes right after the trigger, checked
  // against the page snapshot and the expected halt/ownership lengths.
  task automatic run_dma(input logic [7:0] page, input int nw, input int pad,
                         input int exp_halt, input string tag);
    logic [7:0] exp_b [256];
    logic [7:0] wv [4];
    int trig_t, exp_own, n, bad_d, bad_a, bad_w;
    for (int i = 0; i < pad; i++) cpu_cycle(16'h8000, 1'b1, 8'h00);
    clear_counters();
    trig_t = tick_cnt;
    cpu_cycle(16'h4014, 1'b0, page);
    for (int i = 0; i < 256; i++) exp_b[i] = mem[{page, 8'(i)}];
    for (int k = 0; k < nw; k++) begin
      wv[k] = 8'($urandom);
      cpu_cycle(16'h6000 + 16'(k), 1'b0, wv[k]);
    end
    n = 0;
    s_busy = 1'b1;
    while (s_busy && n < 1200) begin
      cpu_cycle(16'h8000, 1'b1, 8'h00);
      n++;
    end
    // Alignment is needed when the DUMMY tick sees parity 0 (next is a put).
    exp_own = 513 + (((trig_t + nw + 2) % 2 == 0) ? 1 : 0);
    check({tag, " done"}, 32'(s_busy), 32'd0);
    check({tag, " ready_after"}, 32'(s_ready), 32'd1);
    check({tag, " own_after"}, 32'(s_own), 32'd0);
    check({tag, " halt_ticks"}, 32'(halt_cnt), 32'(exp_halt));
    check({tag, " own_ticks"}, 32'(own_cnt), 32'(exp_own));
    check({tag, " ready_low_ticks"}, 32'(ready_low), 32'(exp_halt + exp_own));
    check({tag, " own_on_core_write"}, 32'(own_write), 32'd0);
    check({tag, " oam_writes"}, 32'(oam_q.size()), 32'd256);
    check({tag, " dma_reads"}, 32'(rd_q.size()), 32'd256);
    bad_d = 0;
    bad_a = 0;
    for (int i = 0; i < 256; i++) begin
      if (i < oam_q.size() && oam_q[i] !== exp_b[i]) bad_d++;
      if (i < rd_q.size() && rd_q[i] !== {page, 8'(i)}) bad_a++;
    end
    check({tag, " data_mismatches"}, 32'(bad_d), 32'd0);
    check({tag, " addr_mismatches"}, 32'(bad_a), 32'd0);
    bad_w = 0;
    for (int k = 0; k < nw; k++) if (mem[16'h6000 + 16'(k)] !== wv[k]) bad_w++;
    check({tag, " core_writes_lost"}, 32'(bad_w), 32'd0);
  endtask

  initial begin
    vec_t vecs [6];
    logic [7:0] p;
    int n;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst   = 1'b1;
    phy2  = 1'b0;
    haddr = 16'h0000;
    hrdwr = 1'b1;
    hdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 32'(ready), 32'd1);
    check("reset own", 32'(own), 32'd0);
    check("reset addr", 32'(addr), 32'h0);
    check("reset rdwr", 32'(rdwr), 32'd1);
    check("reset wr_data", 32'(wr_data), 32'h0);
    check("reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick_cnt = 0;

    // Page $02 holds i ^ A5.
    for (int i = 0; i < 256; i++) mem[16'h0200 + 16'(i)] = 8'(i) ^ 8'hA5;
    run_dma(8'h02, 0, 0, 1, "page02");
    check("page02 first byte", 32'(oam_q[0]), 32'hA5);
    check("page02 second byte", 32'(oam_q[1]), 32'hA4);
    check("page02 last byte", 32'(oam_q[255]), 32'h5A);

    vecs[0] = '{page: 8'h02, nw: 0, pad: 0, exp_halt: 1};
    vecs[1] = '{page: 8'h02, nw: 0, pad: 1, exp_halt: 1};
    vecs[2] = '{page: 8'hFF, nw: 0, pad: 0, exp_halt: 1};
    vecs[3] = '{page: 8'h10, nw: 2, pad: 0, exp_halt: 3};
    vecs[4] = '{page: 8'h10, nw: 3, pad: 1, exp_halt: 4};
    vecs[5] = '{page: 8'h81, nw: 1, pad: 0, exp_halt: 2};
    for (int v = 0; v < 6; v++) begin
      run_dma(vecs[v].page, vecs[v].nw, vecs[v].pad, vecs[v].exp_halt,
              $sformatf("vec%0d", v));
    end

    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(0, 3));
      p = 8'($urandom_range(0, 255));
      while (p == 8'h20 || p == 8'h60) p = 8'($urandom_range(0, 255));
      for (int i = 0; i < 256; i++) mem[{p, 8'(i)}] = 8'($urandom);
      run_dma(p, n, int'($urandom_range(0, 3)), n + 1, $sformatf("rnd%0d", r));
    end

    // Reset in the READ cycle of index $40.
    clear_counters();
    cpu_cycle(16'h4014, 1'b0, 8'h05);
    n = 0;
    while (oam_q.size() < 64 && n < 400) begin
      cpu_cycle(16'h8000, 1'b1, 8'h00);
      n++;
    end
    check("midreset reached_index40", 32'(oam_q.size()), 32'd64);
    cpu_cycle(16'h8000, 1'b1, 8'h00, 1'b1);
    check("midreset read_addr", 32'(s_addr), 32'h0540);
    @(posedge clk);
    #1;
    check("midreset ready", 32'(ready), 32'd1);
    check("midreset own", 32'(own), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    run_dma(8'h05, 0, 2, 1, "restart");

    // Non-trigger accesses.
    cpu_cycle(16'h4015, 1'b0, 8'h02);
    cpu_cycle(16'h8000, 1'b1, 8'h00);
    check("write4015 busy", 32'(s_busy), 32'd0);
    check("write4015 ready", 32'(s_ready), 32'd1);
    cpu_cycle(16'h4014, 1'b1, 8'h00);
    cpu_cycle(16'h8000, 1'b1, 8'h00);
    check("read4014 busy", 32'(s_busy), 32'd0);
    check("read4014 ready", 32'(s_ready), 32'd1);

    // Reset on the same clock as the trigger tick.
    cpu_cycle(16'h4014, 1'b0, 8'h03, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_cycle(16'h8000, 1'b1, 8'h00);
    cpu_cycle(16'h8000, 1'b1, 8'h00);
    check("reset_vs_trigger busy", 32'(s_busy), 32'd0);
    check("reset_vs_trigger ready", 32'(s_ready), 32'd1);
    check("reset_vs_trigger own", 32'(s_own), 32'd0);

    // After a page $FF transfer the index must start again at 0.
    run_dma(8'hFF, 0, 0, 1, "pageFF");
    run_dma(8'h03, 1, 0, 2, "after_wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
